// File: rtl/membus_cmd_pkg.sv
// Shared opcodes, response bytes and state encoding for the byte-stream bus command master.
package membus_cmd_pkg;

  localparam logic [7:0] OP_READ     = 8'h01;
  localparam logic [3:0] OP_WRITE_HI = 4'h1;

  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StAddr = 3'd1;
  localparam state_t StData = 3'd2;
  localparam state_t StBus  = 3'd3;
  localparam state_t StRsp  = 3'd4;

  // 0x1N with N != 0 is a write whose low nibble is the byte-enable mask.
  function automatic logic is_write_op(input logic [7:0] op);
    return (op[7:4] == OP_WRITE_HI) && (op[3:0] != 4'h0);
  endfunction

endpackage

// File: rtl/membus_cmd_master.sv
// Turns opcode/address/data byte frames into single-word picorv32 native bus transfers
// and streams ACK/ERR plus read data back as response bytes.
module membus_cmd_master
  import membus_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [7:0] TmoLimit = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        mem_valid_q, mem_valid_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic [2:0]  rsp_rem_q, rsp_rem_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic       cmd_acc;
  logic       rsp_acc;
  logic       go_bus;
  logic       go_err;
  logic [7:0] tmo_inc;

  assign cmd_acc = cmd_valid && cmd_ready_q;
  assign rsp_acc = rsp_valid_q && rsp_ready;
  assign tmo_inc = tmo_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    mem_valid_d = mem_valid_q;
    tmo_d       = tmo_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rem_d   = rsp_rem_q;
    go_bus      = 1'b0;
    go_err      = 1'b0;

    case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          if (cmd_data == OP_READ) begin
            wstrb_d = 4'h0;
            cnt_d   = 2'd0;
            state_d = StAddr;
          end else if (is_write_op(cmd_data)) begin
            wstrb_d = cmd_data[3:0];
            cnt_d   = 2'd0;
            state_d = StAddr;
          end else begin
            go_err = 1'b1;
          end
        end
      end

      StAddr: begin
        if (cmd_acc) begin
          // Little-endian: the first byte ends up in [7:0] after four shifts.
          addr_d = {cmd_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (wstrb_q != 4'h0) begin
              cnt_d   = 2'd0;
              state_d = StData;
            end else if (addr_d[1:0] != 2'b00) begin
              go_err = 1'b1;
            end else begin
              go_bus = 1'b1;
            end
          end
        end
      end

      StData: begin
        if (cmd_acc) begin
          wdata_d = {cmd_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // A misaligned write still swallows its data bytes before reporting ERR.
            if (addr_q[1:0] != 2'b00) begin
              go_err = 1'b1;
            end else begin
              go_bus = 1'b1;
            end
          end
        end
      end

      StBus: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rdata_d     = mem_rdata;
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_data_d  = RSP_ACK;
          rsp_rem_d   = (wstrb_q == 4'h0) ? 3'd4 : 3'd0;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TmoLimit) begin
            mem_valid_d = 1'b0;
            go_err      = 1'b1;
          end
        end
      end

      StRsp: begin
        if (rsp_acc) begin
          if (rsp_rem_q == 3'd0) begin
            rsp_valid_d = 1'b0;
            rsp_data_d  = 8'h00;
            state_d     = StIdle;
          end else begin
            rsp_data_d = rdata_q[7:0];
            rdata_d    = {8'h00, rdata_q[31:8]};
            rsp_rem_d  = rsp_rem_q - 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (go_bus) begin
      state_d     = StBus;
      mem_valid_d = 1'b1;
      tmo_d       = 8'd0;
    end
    if (go_err) begin
      state_d     = StRsp;
      rsp_valid_d = 1'b1;
      rsp_data_d  = RSP_ERR;
      rsp_rem_d   = 3'd0;
    end
  end

  // Registered so the byte source sees a glitch-free ready aligned with the next state.
  assign cmd_ready_d = (state_d == StIdle) || (state_d == StAddr) || (state_d == StData);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      mem_valid_q <= 1'b0;
      tmo_q       <= 8'd0;
      rdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_rem_q   <= 3'd0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      mem_valid_q <= mem_valid_d;
      tmo_q       <= tmo_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rem_q   <= rsp_rem_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_valid = mem_valid_q;
  assign mem_instr = 1'b0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_membus_cmd_master.sv
// Directed bench for membus_cmd_master: frame parsing, bus handshake, timeout, response
// back-pressure and reset recovery, with a small wait-state responder on the memory side.
module tb_membus_cmd_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Responder configuration (written by the stimulus block only).
  int          resp_wait  = 0;
  bit          resp_dead  = 1'b0;
  logic [31:0] resp_rdata = 32'h0;

  // Responder observations (written by the responder block only).
  int          mv_run     = 0;
  int          mv_last    = 0;
  int          mv_bursts  = 0;
  bit          stable_bad = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  always #5 clk = ~clk;

  membus_cmd_master #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Memory responder: ready after resp_wait low cycles; tracks burst length and stability.
  always @(posedge clk) begin
    #1;
    if (mem_valid === 1'b1) begin
      if (mv_run == 0) begin
        cap_addr   = mem_addr;
        cap_wdata  = mem_wdata;
        cap_wstrb  = mem_wstrb;
        stable_bad = 1'b0;
      end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                   mem_wstrb !== cap_wstrb) begin
        stable_bad = 1'b1;
      end
      mem_ready = !resp_dead && (mv_run == resp_wait);
      mem_rdata = mem_ready ? resp_rdata : 32'h0;
      mv_run++;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      if (mv_run > 0) begin
        mv_last = mv_run;
        mv_bursts++;
      end
      mv_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(n < 50), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input bit wr,
                            input logic [31:0] data);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    rsp_ready = 1'b1;
    while (rsp_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check(tag, 32'(rsp_data), 32'(exp));
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check({tag, "_mem_addr"},  mem_addr,       32'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
    check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    int b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check_idle_outputs("reset");
    check("mem_instr", 32'(mem_instr), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Full-strobe write, zero-wait responder
    resp_wait = 0;
    send_frame(8'h1F, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    check("wr_mem_valid", 32'(mem_valid), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h0000_0010);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_mem_wstrb", 32'(mem_wstrb), 32'hF);
    check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    tick();
    check("wr_ack_timing_valid", 32'(rsp_valid), 32'd1);
    check("wr_ack_timing_mv", 32'(mem_valid), 32'd0);
    recv_byte("wr_ack", 8'hAA);
    check("wr_burst_len", 32'(mv_last), 32'd1);
    check("wr_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wr_done_busy", 32'(busy), 32'd0);

    // Read with three wait states; ready arrives as the counter would hit the limit
    resp_wait  = 3;
    resp_rdata = 32'hDEAD_BEEF;
    send_frame(8'h01, 32'h0000_0010, 1'b0, 32'h0);
    check("rd_mem_valid", 32'(mem_valid), 32'd1);
    check("rd_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rd_mem_addr", mem_addr, 32'h0000_0010);
    recv_byte("rd_ack", 8'hAA);
    recv_byte("rd_b0", 8'hEF);
    recv_byte("rd_b1", 8'hBE);
    recv_byte("rd_b2", 8'hAD);
    recv_byte("rd_b3", 8'hDE);
    check("rd_burst_len", 32'(mv_last), 32'd4);
    check("rd_stable", 32'(stable_bad), 32'd0);
    check("rd_done_rsp_valid", 32'(rsp_valid), 32'd0);

    // Bad opcodes respond at once and the next byte is a fresh opcode
    b0 = mv_bursts;
    send_byte(8'h42);
    check("bad42_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bad42_rsp_data", 32'(rsp_data), 32'hEE);
    check("bad42_cmd_ready", 32'(cmd_ready), 32'd0);
    recv_byte("bad42_err", 8'hEE);
    send_byte(8'h10);
    check("bad10_rsp_data", 32'(rsp_data), 32'hEE);
    recv_byte("bad10_err", 8'hEE);
    check("bad_no_bus", 32'(mv_bursts), 32'(b0));
    resp_wait  = 0;
    resp_rdata = 32'h1234_5678;
    send_frame(8'h01, 32'h0000_0020, 1'b0, 32'h0);
    recv_byte("after_bad_ack", 8'hAA);
    recv_byte("after_bad_b0", 8'h78);
    recv_byte("after_bad_b1", 8'h56);
    recv_byte("after_bad_b2", 8'h34);
    recv_byte("after_bad_b3", 8'h12);
    check("after_bad_bursts", 32'(mv_bursts), 32'(b0 + 1));

    // Misaligned read and write: ERR right after the last frame byte, no bus cycle
    b0 = mv_bursts;
    send_frame(8'h01, 32'h0000_0012, 1'b0, 32'h0);
    check("mis_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    recv_byte("mis_rd_err", 8'hEE);
    send_frame(8'h1F, 32'h0000_0002, 1'b1, 32'h5555_AAAA);
    check("mis_wr_rsp_valid", 32'(rsp_valid), 32'd1);
    recv_byte("mis_wr_err", 8'hEE);
    tick();
    check("mis_no_bus", 32'(mv_bursts), 32'(b0));

    // Timeout: dead responder, then a live read recovers
    resp_dead = 1'b1;
    send_frame(8'h01, 32'h0000_0030, 1'b0, 32'h0);
    recv_byte("tmo_err", 8'hEE);
    check("tmo_burst_len", 32'(mv_last), 32'd4);
    check("tmo_mem_valid", 32'(mem_valid), 32'd0);
    resp_dead  = 1'b0;
    resp_wait  = 1;
    resp_rdata = 32'hCAFE_F00D;
    send_frame(8'h01, 32'h0000_0040, 1'b0, 32'h0);
    recv_byte("post_tmo_ack", 8'hAA);
    recv_byte("post_tmo_b0", 8'h0D);
    recv_byte("post_tmo_b1", 8'hF0);
    recv_byte("post_tmo_b2", 8'hFE);
    recv_byte("post_tmo_b3", 8'hCA);

    // Response back-pressure with noise on the command side
    resp_wait  = 0;
    resp_rdata = 32'hA1B2_C3D4;
    send_frame(8'h01, 32'h0000_0050, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 8'($urandom_range(0, 255));
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'hAA);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    recv_byte("bp_ack", 8'hAA);
    recv_byte("bp_b0", 8'hD4);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      check("bp_hold_b1", 32'(rsp_data), 32'hC3);
      tick();
    end
    cmd_valid = 1'b0;
    recv_byte("bp_b1", 8'hC3);
    recv_byte("bp_b2", 8'hB2);
    recv_byte("bp_b3", 8'hA1);
    check("bp_done_cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset while the bus transfer is stalled
    resp_dead = 1'b1;
    send_frame(8'h01, 32'h0000_0060, 1'b0, 32'h0);
    check("rst_bus_mem_valid", 32'(mem_valid), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("rst_bus");
    reset     = 1'b0;
    resp_dead = 1'b0;
    tick();
    check("rst_bus_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_bus_no_rsp", 32'(rsp_valid), 32'd0);
    resp_wait = 0;
    send_frame(8'h13, 32'h0000_0070, 1'b1, 32'h1122_3344);
    check("rst_wr_mem_valid", 32'(mem_valid), 32'd1);
    check("rst_wr_wstrb", 32'(mem_wstrb), 32'h3);
    check("rst_wr_wdata", mem_wdata, 32'h1122_3344);
    check("rst_wr_addr", mem_addr, 32'h0000_0070);
    recv_byte("rst_wr_ack", 8'hAA);
    resp_wait  = 2;
    resp_rdata = 32'h0BAD_F00D;
    send_frame(8'h01, 32'h0000_0070, 1'b0, 32'h0);
    recv_byte("rst_rd_ack", 8'hAA);
    recv_byte("rst_rd_b0", 8'h0D);
    recv_byte("rst_rd_b1", 8'hF0);
    recv_byte("rst_rd_b2", 8'hAD);
    recv_byte("rst_rd_b3", 8'h0B);
    check("rst_rd_burst_len", 32'(mv_last), 32'd3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
